// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Byte/halfword/word load-store engine in front of a word-wide
//               DataMemory port. One request at a time over valid/ready;
//               sub-word stores run as read-modify-write; loads return
//               sign- or zero-extended data with a one-cycle response pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_error,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_writeData,
    output logic                    mem_writeEnable,
    input  logic [DATA_WIDTH-1:0]   mem_readData
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    logic [1:0]            r_state;
    logic                  r_write;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [ADDR_WIDTH+1:0] r_addr;
    // Only the low half of store data is ever merged into an old word;
    // full-word stores are staged straight into r_memWriteData at accept.
    logic [15:0]           r_wdataLow;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_error;
    logic [DATA_WIDTH-1:0] r_memWriteData;

    logic                  w_accept;
    logic                  w_reqError;
    logic [7:0]            w_byteSel;
    logic [15:0]           w_halfSel;
    logic [DATA_WIDTH-1:0] w_loadData;
    logic [DATA_WIDTH-1:0] w_mergedWord;

    assign w_accept = req_valid && req_ready;

    // Classify the incoming request: illegal size or misaligned address.
    always_comb begin
        w_reqError = 1'b0;
        case (req_size)
            c_SIZE_BYTE: w_reqError = 1'b0;
            c_SIZE_HALF: w_reqError = req_addr[0];
            c_SIZE_WORD: w_reqError = |req_addr[1:0];
            default:     w_reqError = 1'b1;
        endcase
    end

    // Pick the addressed little-endian lane and extend it to a full word.
    always_comb begin
        w_byteSel = 8'h00;
        case (r_addr[1:0])
            2'd0:    w_byteSel = mem_readData[7:0];
            2'd1:    w_byteSel = mem_readData[15:8];
            2'd2:    w_byteSel = mem_readData[23:16];
            default: w_byteSel = mem_readData[31:24];
        endcase
        w_halfSel = r_addr[1] ? mem_readData[31:16] : mem_readData[15:0];
        w_loadData = mem_readData;
        case (r_size)
            c_SIZE_BYTE: w_loadData = {{24{!r_unsigned && w_byteSel[7]}}, w_byteSel};
            c_SIZE_HALF: w_loadData = {{16{!r_unsigned && w_halfSel[15]}}, w_halfSel};
            default:     w_loadData = mem_readData;
        endcase
    end

    // Replace the addressed lane(s) of the old word with the store data.
    always_comb begin
        w_mergedWord = mem_readData;
        if (r_size == c_SIZE_BYTE) begin
            case (r_addr[1:0])
                2'd0:    w_mergedWord[7:0]   = r_wdataLow[7:0];
                2'd1:    w_mergedWord[15:8]  = r_wdataLow[7:0];
                2'd2:    w_mergedWord[23:16] = r_wdataLow[7:0];
                default: w_mergedWord[31:24] = r_wdataLow[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_mergedWord[31:16] = r_wdataLow;
        end else begin
            w_mergedWord[15:0] = r_wdataLow;
        end
    end

    // Request sequencer; response registers only change on entry to RESP so
    // they hold their value between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_write        <= 1'b0;
            r_size         <= 2'b00;
            r_unsigned     <= 1'b0;
            r_addr         <= '0;
            r_wdataLow     <= 16'h0000;
            r_rdata        <= '0;
            r_error        <= 1'b0;
            r_memWriteData <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdataLow <= req_wdata[15:0];
                        if (w_reqError) begin
                            r_error <= 1'b1;
                            r_rdata <= '0;
                            r_state <= c_RESP;
                        end else if (req_write && req_size == c_SIZE_WORD) begin
                            r_memWriteData <= req_wdata;
                            r_state        <= c_WRITE;
                        end else begin
                            r_state <= c_READ;
                        end
                    end
                end
                c_READ: begin
                    if (r_write) begin
                        r_memWriteData <= w_mergedWord;
                        r_state        <= c_WRITE;
                    end else begin
                        r_rdata <= w_loadData;
                        r_error <= 1'b0;
                        r_state <= c_RESP;
                    end
                end
                c_WRITE: begin
                    r_rdata <= '0;
                    r_error <= 1'b0;
                    r_state <= c_RESP;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by rst so they drop the instant reset asserts.
    assign req_ready       = (r_state == c_IDLE)  && !rst;
    assign resp_valid      = (r_state == c_RESP)  && !rst;
    assign mem_writeEnable = (r_state == c_WRITE) && !rst;
    assign resp_rdata      = r_rdata;
    assign resp_error      = r_error;
    assign mem_address     = r_addr[ADDR_WIDTH+1:2];
    assign mem_writeData   = r_memWriteData;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit: directed scenarios
//               plus randomized requests against an arithmetic reference model
//               of the memory and of the load/store semantics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int c_AW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [c_AW+1:0] req_addr;
    logic [31:0]     req_wdata;
    logic            resp_valid;
    logic [31:0]     resp_rdata;
    logic            resp_error;
    logic [c_AW-1:0] mem_address;
    logic [31:0]     mem_writeData;
    logic            mem_writeEnable;
    logic [31:0]     mem_readData;

    logic [31:0] mem    [0:255];
    logic [31:0] refMem [0:255];

    int nTests = 0;
    int nFail  = 0;
    logic [31:0] lastRdata;
    logic        lastErr;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(c_AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_address(mem_address),
        .mem_writeData(mem_writeData), .mem_writeEnable(mem_writeEnable),
        .mem_readData(mem_readData)
    );

    always #5 clk = ~clk;

    // DataMemory: combinational read, write on rising edge while strobed
    assign mem_readData = mem[mem_address];
    always @(posedge clk) if (mem_writeEnable) mem[mem_address] <= mem_writeData;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit refIsErr(input logic [1:0] size, input logic [9:0] addr);
        int a = int'(addr);
        return (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [1:0] size,
                                            input logic uns, input logic [9:0] addr);
        int a = int'(addr);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (word >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] refStore(input logic [31:0] old, input logic [1:0] size,
                                             input logic [9:0] addr, input logic [31:0] wdata);
        int a = int'(addr);
        logic [31:0] mask;
        int sh;
        if (size == 2'd2) return wdata;
        sh   = (size == 2'd0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
        mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~mask) | ((wdata << sh) & mask);
    endfunction

    task automatic checkOutputsZero(input string tag);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
        check({tag, "_rvalid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_rerr"}, {31'd0, resp_error}, 32'd0);
        check({tag, "_we"}, {31'd0, mem_writeEnable}, 32'd0);
        check({tag, "_rdata"}, resp_rdata, 32'd0);
        check({tag, "_maddr"}, {24'd0, mem_address}, 32'd0);
        check({tag, "_wdata"}, mem_writeData, 32'd0);
    endtask

    // Drive one request at a negedge, let it be accepted, then watch it complete.
    task automatic doReq(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wdata);
        int idx = int'(addr[9:2]);
        bit err = refIsErr(size, addr);
        logic [31:0] expWord = refMem[idx];
        logic [31:0] expRdata = 32'd0;
        int expLat, lat = 0, weCount = 0, weCyc = 0;
        bit gotResp = 0;
        if (!err && wr) expWord = refStore(refMem[idx], size, addr, wdata);
        if (!err && !wr) expRdata = refLoad(refMem[idx], size, uns, addr);
        expLat = err ? 1 : (wr && size != 2'd2) ? 3 : 2;

        @(negedge clk);
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = 10'($urandom); req_wdata = $urandom;
        req_size = 2'($urandom); req_write = 1'($urandom);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) check("ready_busy", {31'd0, req_ready}, 32'd0);
            if (mem_writeEnable) begin
                weCount++;
                weCyc = cyc;
                check("we_addr", {24'd0, mem_address}, idx);
                check("we_data", mem_writeData, expWord);
            end
            if (resp_valid) begin
                gotResp   = 1;
                lat       = cyc;
                lastRdata = resp_rdata;
                lastErr   = resp_error;
                break;
            end
        end
        check("resp_seen", {31'd0, gotResp}, 32'd1);
        check("latency", lat, expLat);
        check("resp_error", {31'd0, lastErr}, {31'd0, err});
        check("resp_rdata", lastRdata, expRdata);
        check("we_count", weCount, (wr && !err) ? 1 : 0);
        if (wr && !err) check("we_cycle", weCyc, expLat - 1);
        refMem[idx] = expWord;
        check("mem_word", mem[idx], refMem[idx]);
        @(negedge clk);
        check("resp_pulse", {31'd0, resp_valid}, 32'd0);
        check("ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'd0;
            refMem[i] = 32'd0;
        end
        lastRdata = 32'd0; lastErr = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'd0;
        rst = 1'b1;
        #3;
        checkOutputsZero("rst0");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", {31'd0, req_ready}, 32'd1);
        check("rel_we", {31'd0, mem_writeEnable}, 32'd0);

        // Word round trip
        doReq(1'b1, 2'd2, 1'b0, 10'h10, 32'h11223344);
        doReq(1'b0, 2'd2, 1'b0, 10'h10, 32'h0);
        check("lw_const", lastRdata, 32'h11223344);

        // Byte store over 0xAABBCCDD and byte loads
        doReq(1'b1, 2'd2, 1'b0, 10'h10, 32'hAABBCCDD);
        doReq(1'b1, 2'd0, 1'b0, 10'h12, 32'hDEAD037F);
        check("sb_mem_const", mem[4], 32'hAA7FCCDD);
        doReq(1'b0, 2'd0, 1'b0, 10'h13, 32'h0);
        check("lb_13", lastRdata, 32'hFFFFFFAA);
        doReq(1'b0, 2'd0, 1'b1, 10'h13, 32'h0);
        check("lbu_13", lastRdata, 32'h000000AA);
        doReq(1'b0, 2'd0, 1'b0, 10'h12, 32'h0);
        check("lb_12", lastRdata, 32'h0000007F);

        // Halfword onto a zero word
        doReq(1'b1, 2'd1, 1'b0, 10'h0E, 32'h12348001);
        check("sh_mem_const", mem[3], 32'h80010000);
        doReq(1'b0, 2'd1, 1'b0, 10'h0E, 32'h0);
        check("lh_0e", lastRdata, 32'hFFFF8001);
        doReq(1'b0, 2'd1, 1'b1, 10'h0E, 32'h0);
        check("lhu_0e", lastRdata, 32'h00008001);

        // Error requests
        doReq(1'b0, 2'd2, 1'b0, 10'h11, 32'h0);
        check("err_lw", {31'd0, lastErr}, 32'd1);
        doReq(1'b1, 2'd1, 1'b0, 10'h03, 32'hFFFF);
        check("err_sh", {31'd0, lastErr}, 32'd1);
        doReq(1'b1, 2'd3, 1'b0, 10'h10, 32'h0BADBEEF);
        check("err_sz", {31'd0, lastErr}, 32'd1);
        check("err_mem4", mem[4], 32'hAA7FCCDD);

        // Reset landing in READ of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
        req_addr = 10'h12; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkOutputsZero("rstrd");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rstrd_noresp", {30'd0, resp_valid, mem_writeEnable}, 32'd0);
        end
        check("rstrd_mem", mem[4], refMem[4]);
        check("rstrd_ready", {31'd0, req_ready}, 32'd1);

        // Reset landing in WRITE of a word store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
        req_addr = 10'h20; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rstwr_we_before", {31'd0, mem_writeEnable}, 32'd1);
        #2 rst = 1'b1;
        #1 check("rstwr_we_drop", {31'd0, mem_writeEnable}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstwr_mem", mem[8], refMem[8]);
        check("rstwr_noresp", {31'd0, resp_valid}, 32'd0);

        // Randomized traffic over a small window of words
        for (int n = 0; n < 150; n++) begin
            doReq(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                  10'($urandom_range(0, 63)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
